// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive input sweeper for a small sequential DUT, streaming (pattern, response) pairs.
// Optional 16-bit MISR signature output enabled by PATTERN_SWEEP_SIGNATURE_EN.
module pattern_sweep_ctrl #(
  parameter int unsigned N_IN    = 5,
  parameter int unsigned OUT_W   = 1,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned RST_CYC = 2
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 dut_rst,
  output logic [N_IN-1:0]      dut_in,
  input  logic [OUT_W-1:0]     dut_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [N_IN-1:0]      resp_pattern,
  output logic [OUT_W-1:0]     resp_data,
  output logic [(1<<N_IN)-1:0] result
`ifdef PATTERN_SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]          signature
`endif
);

  localparam int unsigned CntMax = (SETTLE > RST_CYC) ? SETTLE : RST_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [N_IN:0]   PatOne = 1;

  typedef enum logic [2:0] {StIdle, StDrst, StApply, StEmit, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  // One bit wider than the pattern so the counter never wraps back to zero.
  logic [N_IN:0]   pat_q;
  logic            last_pat;

  assign last_pat = ~pat_q[N_IN] & (&pat_q[N_IN-1:0]);

`ifdef PATTERN_SWEEP_SIGNATURE_EN
  // Galois form of x^16+x^12+x^5+1 with the input word folded in after the shift.
  function automatic logic [15:0] misr_step(logic [15:0] s, logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction
`endif

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pat_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dut_rst      <= 1'b0;
      dut_in       <= '0;
      resp_valid   <= 1'b0;
      resp_pattern <= '0;
      resp_data    <= '0;
      result       <= '0;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
      signature    <= '0;
`endif
    end else if (abort) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      dut_rst    <= 1'b0;
      dut_in     <= '0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q <= StDrst;
            busy    <= 1'b1;
            dut_rst <= 1'b1;
            dut_in  <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            result  <= '0;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
            signature <= '0;
`endif
          end
        end
        StDrst: begin
          if (cnt_q == CntW'(RST_CYC - 1)) begin
            state_q <= StApply;
            dut_rst <= 1'b0;
            cnt_q   <= '0;
            dut_in  <= pat_q[N_IN-1:0];
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StApply: begin
          if (cnt_q == CntW'(SETTLE - 1)) begin
            state_q                  <= StEmit;
            cnt_q                    <= '0;
            resp_valid               <= 1'b1;
            resp_pattern             <= pat_q[N_IN-1:0];
            resp_data                <= dut_out;
            result[pat_q[N_IN-1:0]]  <= dut_out[0];
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StEmit: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
            signature  <= misr_step(signature, 16'({resp_pattern, resp_data}));
`endif
            if (last_pat) begin
              state_q <= StDone;
              done    <= 1'b1;
              dut_in  <= '0;
            end else begin
              state_q <= StApply;
              pat_q   <= pat_q + PatOne;
              dut_in  <= N_IN'(pat_q + PatOne);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Randomized self-checking bench for pattern_sweep_ctrl against a parity DUT model;
// covers the signature output when PATTERN_SWEEP_SIGNATURE_EN is defined.
module tb_pattern_sweep_ctrl;

  localparam int unsigned N  = 5;
  localparam int unsigned NP = 1 << N;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic reset, start1, start2, abort, resp_ready, sel;

  logic          busy1, done1, drst1, valid1, busy2, done2, drst2, valid2;
  logic [N-1:0]  in1, pat1, in2, pat2;
  logic [0:0]    out1, dat1, out2, dat2;
  logic [NP-1:0] res1, res2;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
  logic [15:0]   sig1, sig2, o_sig;
`endif

  // Parity DUT under test
  assign out1 = ^in1;
  assign out2 = ^in2;

  pattern_sweep_ctrl u_dut (
    .CK(CK), .reset(reset), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .dut_rst(drst1), .dut_in(in1), .dut_out(out1), .resp_valid(valid1),
    .resp_ready(resp_ready), .resp_pattern(pat1), .resp_data(dat1), .result(res1)
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    , .signature(sig1)
`endif
  );

  pattern_sweep_ctrl #(.N_IN(5), .OUT_W(1), .SETTLE(3), .RST_CYC(1)) u_dut2 (
    .CK(CK), .reset(reset), .start(start2), .abort(abort), .busy(busy2), .done(done2),
    .dut_rst(drst2), .dut_in(in2), .dut_out(out2), .resp_valid(valid2),
    .resp_ready(resp_ready), .resp_pattern(pat2), .resp_data(dat2), .result(res2)
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    , .signature(sig2)
`endif
  );

  logic          o_busy, o_done, o_drst, o_valid;
  logic [N-1:0]  o_in, o_pat;
  logic [0:0]    o_dat;
  logic [NP-1:0] o_res;
  assign o_busy  = sel ? busy2  : busy1;
  assign o_done  = sel ? done2  : done1;
  assign o_drst  = sel ? drst2  : drst1;
  assign o_valid = sel ? valid2 : valid1;
  assign o_in    = sel ? in2    : in1;
  assign o_pat   = sel ? pat2   : pat1;
  assign o_dat   = sel ? dat2   : dat1;
  assign o_res   = sel ? res2   : res1;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
  assign o_sig   = sel ? sig2   : sig1;
`endif

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_sweep
  int r_pat[$], r_dat[$], r_cyc[$], r_stall[$];
  int unstable, stalls, done_cyc, done_cnt, rst_cnt, abort_cyc;
  bit timeout, busy0, busy_after, ab_busy, ab_valid, aborted;
  logic [15:0] sig_done, sig_after;

  function automatic int parity(int v);
    return $countones(v) % 2;
  endfunction

  function automatic logic [NP-1:0] model_result();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = 1'(parity(p));
    return r;
  endfunction

  // Drives one sweep from start and records what the DUT produced; called at posedge+1.
  task automatic run_sweep(input bit use2, input int stall_pct, input int abort_pat);
    bit in_emit, rdy;
    int cyc, prev_pat, prev_dat;
    sel = use2;
    r_pat.delete(); r_dat.delete(); r_cyc.delete(); r_stall.delete();
    unstable = 0; stalls = 0; done_cyc = -1; done_cnt = 0; rst_cnt = 0; abort_cyc = -1;
    timeout = 0; aborted = 0; in_emit = 0; prev_pat = 0; prev_dat = 0;
    abort = 0; resp_ready = 0;
    if (use2) start2 = 1; else start1 = 1;
    @(posedge CK); #1;
    start1 = 0; start2 = 0;
    cyc = 0;
    busy0 = o_busy;
    forever begin
      if (o_drst) rst_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
          sig_done = o_sig;
`endif
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = o_busy;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        sig_after = o_sig;
`endif
        break;
      end
      if (aborted && cyc == abort_cyc + 1) begin
        ab_busy = o_busy;
        ab_valid = o_valid;
      end
      if (aborted && cyc == abort_cyc + 80) break;
      if (cyc > 3000) begin
        timeout = 1;
        break;
      end
      if (o_valid) begin
        if (!in_emit) begin
          r_pat.push_back(int'(o_pat));
          r_dat.push_back(int'(o_dat));
          r_cyc.push_back(cyc);
          r_stall.push_back(stalls);
        end else if (int'(o_pat) != prev_pat || int'(o_dat) != prev_dat) begin
          unstable++;
        end
        if (o_in != o_pat) unstable++;
        prev_pat = int'(o_pat);
        prev_dat = int'(o_dat);
      end
      rdy = ($urandom_range(99) >= stall_pct);
      resp_ready = rdy;
      abort = 0;
      if (abort_pat >= 0 && !aborted && o_valid && int'(o_pat) == abort_pat) begin
        abort = 1;
        aborted = 1;
        abort_cyc = cyc;
      end else if (o_valid && !rdy) begin
        stalls++;
      end
      in_emit = o_valid && !rdy;
      @(posedge CK); #1;
      cyc++;
    end
    abort = 0;
    resp_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0; start1 = 0; start2 = 0; abort = 0; resp_ready = 0; sel = 0;
    repeat (2) @(posedge CK);
    #1;
    checks++;
    if ({busy1, done1, drst1, in1, valid1, pat1, dat1, res1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b rst=%0b in=%0d valid=%0b res=%h exp all 0",
               busy1, done1, drst1, in1, valid1, res1);
    end
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    checks++;
    if (sig1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_signature got %h exp 0000", sig1);
    end
`endif
    reset = 1;
    repeat (3) @(posedge CK);
    #1;
    checks++;
    if ({busy1, busy2, valid1, valid2, drst1, drst2} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%0b/%0b valid=%0b/%0b exp 0", busy1, busy2,
               valid1, valid2);
    end
  endtask

  task automatic test_sweep(input string name, input bit use2, input int stall_pct,
                            input int rstc, input int settle);
    logic [NP-1:0] exp_res;
    int exp_cyc;
    exp_res = model_result();
    run_sweep(use2, stall_pct, -1);
    checks++;
    if (timeout !== 0) begin
      errors++;
      $display("FAIL %s timeout got no done exp done", name);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %0b exp 1", name, busy0);
    end
    checks++;
    if (rst_cnt !== rstc) begin
      errors++;
      $display("FAIL %s dut_rst_cycles got %0d exp %0d", name, rst_cnt, rstc);
    end
    checks++;
    if (r_pat.size() !== NP) begin
      errors++;
      $display("FAIL %s resp_count got %0d exp %0d", name, r_pat.size(), NP);
    end
    for (int k = 0; k < NP && k < r_pat.size(); k++) begin
      exp_cyc = rstc + k * (settle + 1) + settle + r_stall[k];
      checks++;
      if (r_pat[k] !== k || r_dat[k] !== parity(k)) begin
        errors++;
        $display("FAIL %s resp[%0d] got pattern=%0d data=%0d exp pattern=%0d data=%0d", name, k,
                 r_pat[k], r_dat[k], k, parity(k));
      end
      checks++;
      if (r_cyc[k] !== exp_cyc) begin
        errors++;
        $display("FAIL %s valid_cycle[%0d] got %0d exp %0d", name, k, r_cyc[k], exp_cyc);
      end
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL %s stall_stability got %0d changes exp 0", name, unstable);
    end
    checks++;
    if (done_cyc !== rstc + NP * (settle + 1) + stalls) begin
      errors++;
      $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc,
               rstc + NP * (settle + 1) + stalls);
    end
    checks++;
    if (done_cnt !== 1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got pulses=%0d busy_after=%0b exp 1 and 0", name, done_cnt,
               busy_after);
    end
    checks++;
    if (o_res !== exp_res) begin
      errors++;
      $display("FAIL %s result got %h exp %h", name, o_res, exp_res);
    end
    if (stall_pct > 0) begin
      checks++;
      if (stalls <= 0) begin
        errors++;
        $display("FAIL %s stalls_seen got %0d exp >0", name, stalls);
      end
    end
  endtask

  task automatic test_abort();
    logic [NP-1:0] exp_res;
    exp_res = model_result();
    run_sweep(0, 0, 10);
    checks++;
    if (aborted !== 1'b1 || r_pat.size() !== 11) begin
      errors++;
      $display("FAIL abort_reached got aborted=%0b responses=%0d exp 1 and 11", aborted,
               r_pat.size());
    end
    checks++;
    if (ab_busy !== 1'b0 || ab_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_cycle got busy=%0b valid=%0b exp 0 0", ab_busy, ab_valid);
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses exp 0", done_cnt);
    end
    checks++;
    if (res1[NP-1:10] !== '0 || res1[9:0] !== exp_res[9:0]) begin
      errors++;
      $display("FAIL abort_partial_result got %h exp %h", res1, {{(NP-10){1'b0}}, exp_res[9:0]});
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int bad;
    sel = 0;
    found = 0;
    start1 = 1;
    @(posedge CK); #1;
    start1 = 0;
    resp_ready = 1;
    for (int c = 0; c < 200; c++) begin
      if (busy1 && !drst1 && !valid1 && in1 == 5'd5) begin
        found = 1;
        break;
      end
      @(posedge CK); #1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL async_reset_reach_apply5 got not reached exp reached");
    end
    #3 reset = 0;
    #1;
    checks++;
    if ({busy1, done1, drst1, in1, valid1, pat1, dat1, res1} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got busy=%0b rst=%0b in=%0d valid=%0b pat=%0d res=%h exp 0",
               busy1, drst1, in1, valid1, pat1, res1);
    end
    #2 reset = 1;
    resp_ready = 0;
    bad = 0;
    repeat (6) begin
      @(posedge CK); #1;
      if (busy1 || valid1 || drst1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL async_reset_stays_idle got %0d active cycles exp 0", bad);
    end
  endtask

`ifdef PATTERN_SWEEP_SIGNATURE_EN
  task automatic test_signature();
    int s, w;
    s = 0;
    for (int p = 0; p < NP; p++) begin
      w = (p << 1) | parity(p);
      s = ((s << 1) ^ (((s >> 15) & 1) != 0 ? 'h1021 : 0) ^ w) & 'hFFFF;
    end
    for (int run = 0; run < 2; run++) begin
      run_sweep(0, 20, -1);
      checks++;
      if (sig_done !== 16'(s)) begin
        errors++;
        $display("FAIL signature_run%0d got %h exp %h", run, sig_done, 16'(s));
      end
      checks++;
      if (sig_after !== 16'(s)) begin
        errors++;
        $display("FAIL signature_hold_run%0d got %h exp %h", run, sig_after, 16'(s));
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep("full_sweep", 0, 0, 2, 1);
    test_sweep("stall_sweep", 0, 30, 2, 1);
    test_abort();
    test_sweep("rerun_after_abort", 0, 0, 2, 1);
    test_async_reset();
    test_sweep("settle3_rst1", 1, 0, 1, 3);
    test_sweep("settle3_stall", 1, 30, 1, 3);
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    test_signature();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
